ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable,
//  0xFF reset) to the keyboard on the same PS2_CLK/PS2_DATA pins the Keyboard receiver listens on.
//  Runs the full host request: clock inhibit, start bit, 8 data bits LSB-first, odd parity, stop bit,
//  device ACK. Drives the bus open-drain through *_oe outputs. Asserts busy so the receiver ignores the bus.
// PARAMETERS
//  CLK_HZ          100_000_000  system clock frequency (documentation; derived defaults below)
//  INHIBIT_CYCLES  12_000       cycles PS/2 clock is held low before start bit (120 us)
//  TIMEOUT_CYCLES  1_500_000    max cycles without a device falling edge before abort (15 ms)
//  FILTER_LEN      8            consecutive equal samples required to change filtered line level
// PORTS
//  clk          in   1  system clock; the only clock
//  rst          in   1  synchronous, active-high reset
//  tx_data      in   8  command byte, sampled on accept
//  tx_valid     in   1  request; accepted when tx_valid && tx_ready
//  tx_ready     out  1  high only in IDLE
//  tx_done      out  1  1-cycle pulse: byte sent and ACK (data low) received
//  tx_err       out  1  1-cycle pulse: timeout or missing ACK
//  busy         out  1  high from accept until tx_done/tx_err; receiver gates key_event with it
//  ps2_clk_i    in   1  raw PS2_CLK pin level (asynchronous)
//  ps2_data_i   in   1  raw PS2_DATA pin level (asynchronous)
//  ps2_clk_oe   out  1  1 = drive PS2_CLK low, 0 = release (pull-up)
//  ps2_data_oe  out  1  1 = drive PS2_DATA low, 0 = release
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1; tx_done=tx_err=busy=0; both *_oe=0; all counters 0. Reset asserted
//   mid-transfer releases both lines on the next edge; no done/err pulse is generated.
//  Inputs: 2-FF synchronizer, then level filter (FILTER_LEN). Falling edge = filtered clock 1->0,
//   one-cycle strobe fe. Input-to-fe latency = 2 + FILTER_LEN cycles.
//  Frame: shift reg {stop=1, parity=~^tx_data, tx_data} captured on accept; odd parity (0xED -> 1, 0xF4 -> 0).
//  FSM:
//   IDLE    : tx_ready=1. On accept -> INHIBIT; busy=1, ps2_clk_oe=1 from the next cycle.
//   INHIBIT : ps2_clk_oe=1 for INHIBIT_CYCLES; data_oe set to 1 on the final inhibit cycle -> REQ.
//   REQ     : clk_oe=0 (released), data_oe=1 (start bit 0). Wait for fe #1 -> BITS, bit index 0.
//   BITS    : on each fe, data_oe <= ~frame[idx]; idx 0..7 data, 8 parity, 9 stop (data released).
//             fe #1 presents d0 ... fe #10 presents stop. After fe #10 -> ACK.
//   ACK     : on fe #11 sample filtered data: 0 -> WAITIDLE, 1 -> ERR.
//   WAITIDLE: wait for filtered clk=1 and data=1 -> DONE.
//   DONE    : tx_done=1 one cycle -> IDLE. ERR: tx_err=1 one cycle, both oe=0 -> IDLE.
//  Timeout: counter cleared on entering REQ and on every fe; reaching TIMEOUT_CYCLES in REQ, BITS,
//   ACK or WAITIDLE -> ERR (both lines released the same edge ERR is entered).
//  tx_valid while busy is ignored (not queued); tx_data changes after accept have no effect.
//  tx_done and tx_err never both high; busy deasserts the cycle after the pulse.
//  A glitch shorter than FILTER_LEN on ps2_clk_i produces no fe.
// STRUCTURE
//  ps2_pkg: FSM state encoding; command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4,
//   PS2_CMD_RESET=8'hFF, PS2_ACK=8'hFA; default INHIBIT/TIMEOUT values shared with the receiver.
//  Sub-module ps2_line_filter (sync + level filter + falling-edge strobe), instantiated twice
//   (clk, data); the Keyboard receiver reuses it.
//  Top wires: PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, same for PS2_DATA.
// TESTING
//  Device model (clock 12.5 kHz, ACK on 11th) + tx 0xED -> data_oe bits 1,0,1,1,0,1,1,1, parity 1, stop
//   released; tx_done one pulse; busy high for whole transfer.
//  tx 0xF4 -> parity presented as 0; clk_oe high exactly INHIBIT_CYCLES cycles before release.
//  Device never clocks -> tx_err pulse TIMEOUT_CYCLES after REQ entry; both oe=0; tx_ready returns 1.
//  Device leaves data high on 11th edge -> tx_err, no tx_done.
//  rst asserted during BITS (bit 4) -> next cycle clk_oe=data_oe=0, tx_ready=1, no pulses.
//  tx_valid held high during transfer + 3-cycle glitch on ps2_clk_i -> second byte not started
//   until after done; glitch causes no bit shift.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmitter state encoding, debug view,
// command constants, timing defaults and the frame builder.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_INHIBIT  = 3'd1,
      ST_REQ      = 3'd2,
      ST_BITS     = 3'd3,
      ST_ACK      = 3'd4,
      ST_WAITIDLE = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERR      = 3'd7
   } ps2_state_e;

   // Observability bundle for checkers: FSM state plus the filtered bus view.
   typedef struct packed {
      ps2_state_e state;
      logic [3:0] bit_idx;
      logic       clk_level;
      logic       data_level;
      logic       clk_fe;
      logic       data_fe;
   } ps2_dbg_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_ACK         = 8'hFA;

   // Timing defaults shared with the keyboard receiver.
   localparam int PS2_CLK_HZ_DEF     = 100_000_000;
   localparam int PS2_INHIBIT_US     = 120;
   localparam int PS2_TIMEOUT_US     = 15_000;
   localparam int PS2_FILTER_LEN_DEF = 8;

   // Bits in wire order from bit 0: d0..d7, odd parity, stop.
   function automatic logic [9:0] ps2_frame(input logic [7:0] d);
      return {1'b1, ~^d, d};
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 pin, debounces it with a run-length level filter
// and emits a one-cycle strobe when the filtered level falls.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic fe
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    sync_q;
   logic          filt_q;
   logic [CW-1:0] run_q;
   logic          fe_q;

   // Two-flop synchronizer, then change level only after FILTER_LEN equal differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= 2'b11;
         filt_q <= 1'b1;
         run_q  <= '0;
         fe_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], din};
         fe_q   <= 1'b0;
         if (sync_q[1] == filt_q) begin
            run_q <= '0;
         end else if (run_q == CW'(FILTER_LEN - 1)) begin
            filt_q <= sync_q[1];
            run_q  <= '0;
            fe_q   <= ~sync_q[1];
         end else begin
            run_q <= run_q + 1'b1;
         end
      end
   end

   assign level = filt_q;
   assign fe    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues the request-to-send,
// shifts out one command byte on device clock falling edges and checks the ACK.
// The pins are open-drain at the pad: PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz, same for PS2_DATA.
//
// Handshake: a byte is accepted on a rising clk edge where tx_valid && tx_ready;
// tx_ready is high only in IDLE, tx_data is captured on that edge and ignored
// afterwards, and tx_valid seen while busy is dropped rather than queued.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLK_HZ         = PS2_CLK_HZ_DEF,
   parameter int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * PS2_INHIBIT_US,
   parameter int TIMEOUT_CYCLES = CLK_HZ / 1_000_000 * PS2_TIMEOUT_US,
   parameter int FILTER_LEN     = PS2_FILTER_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       tx_err,
   output logic       busy,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output ps2_dbg_t   dbg
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   ps2_state_e    state_q;
   logic [9:0]    frame_q;
   logic [3:0]    idx_q;
   logic [CNT_W-1:0] cnt_q;
   logic          clk_lvl, clk_fe;
   logic          data_lvl, data_fe;
   logic          expired;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_clk_i),
      .level (clk_lvl),
      .fe    (clk_fe)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
      .clk   (clk),
      .rst   (rst),
      .din   (ps2_data_i),
      .level (data_lvl),
      .fe    (data_fe)
   );

   // Shared counter: inhibit length in INHIBIT, cycles since last device edge elsewhere.
   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Transfer sequencer with registered handshake, pulse and pin-enable outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         frame_q     <= '0;
         idx_q       <= '0;
         cnt_q       <= '0;
         tx_ready    <= 1'b1;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         busy        <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (tx_valid) begin
                  frame_q    <= ps2_frame(tx_data);
                  cnt_q      <= '0;
                  idx_q      <= '0;
                  tx_ready   <= 1'b0;
                  busy       <= 1'b1;
                  ps2_clk_oe <= 1'b1;
                  state_q    <= ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               cnt_q <= cnt_q + 1'b1;
               // Start bit goes low one cycle before the clock is released.
               if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) ps2_data_oe <= 1'b1;
               if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                  cnt_q       <= '0;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b1;
                  state_q     <= ST_REQ;
               end
            end
            ST_REQ, ST_BITS, ST_ACK, ST_WAITIDLE: begin
               if (state_q == ST_WAITIDLE && clk_lvl && data_lvl) begin
                  tx_done <= 1'b1;
                  state_q <= ST_DONE;
               end else if (clk_fe && state_q != ST_WAITIDLE) begin
                  cnt_q <= '0;
                  if (state_q == ST_ACK) begin
                     if (data_lvl) begin
                        tx_err      <= 1'b1;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state_q     <= ST_ERR;
                     end else begin
                        state_q <= ST_WAITIDLE;
                     end
                  end else begin
                     // Each falling edge presents the next frame bit; the stop bit releases data.
                     ps2_data_oe <= ~frame_q[idx_q];
                     idx_q       <= idx_q + 4'd1;
                     if (state_q == ST_REQ) state_q <= ST_BITS;
                     else if (idx_q == 4'd9) state_q <= ST_ACK;
                  end
               end else if (expired) begin
                  tx_err      <= 1'b1;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= 1'b0;
                  state_q     <= ST_ERR;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ST_DONE, ST_ERR: begin
               busy        <= 1'b0;
               tx_ready    <= 1'b1;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: begin
               busy        <= 1'b0;
               tx_ready    <= 1'b1;
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign dbg = '{state: state_q, bit_idx: idx_q, clk_level: clk_lvl,
                  data_level: data_lvl, clk_fe: clk_fe, data_fe: data_fe};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain bus with a behavioural keyboard model that
// clocks the frame in, records the line levels it sees and optionally ACKs.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INHIBIT = 40;
   localparam int TIMEOUT = 600;
   localparam int FILT    = 8;
   localparam int HALF    = 40;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] tx_data  = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
   ps2_dbg_t   dbg;

   logic dev_clk_low  = 1'b0;
   logic dev_data_low = 1'b0;
   logic dev_glitch   = 1'b0;
   logic ps2_clk_i, ps2_data_i;

   assign ps2_clk_i  = !(ps2_clk_oe || dev_clk_low || dev_glitch);
   assign ps2_data_i = !(ps2_data_oe || dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .TIMEOUT_CYCLES (TIMEOUT),
      .FILTER_LEN     (FILT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .busy        (busy),
      .ps2_clk_i   (ps2_clk_i),
      .ps2_data_i  (ps2_data_i),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .dbg         (dbg)
   );

   // ---------------- scoreboard state ----------------
   int compared = 0;
   int mismatched = 0;
   logic [7:0] exp_q[$];
   int done_cnt = 0, err_cnt = 0, both_cnt = 0, ready_busy_cnt = 0;
   int inh_run = 0, last_inh_len = 0, inh_count = 0, busy_gap = 0;

   // Reference frame as line levels: data LSB first, then odd parity, then stop.
   function automatic logic [9:0] model_frame(input logic [7:0] b);
      int   ones;
      logic par;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      par = (ones % 2 == 0) ? 1'b1 : 1'b0;
      return {1'b1, par, b};
   endfunction

   always @(negedge clk) begin
      if (tx_done) done_cnt++;
      if (tx_err) err_cnt++;
      if (tx_done && tx_err) both_cnt++;
      if (tx_ready && busy) ready_busy_cnt++;
      if (ps2_clk_oe) inh_run++;
      else if (inh_run != 0) begin
         last_inh_len = inh_run;
         inh_count++;
         inh_run = 0;
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation time limit reached, summary not printed");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
      tx_valid = 1'b1;
      tx_data  = b;
      exp_q.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
   endtask

   task automatic wait_idle(output bit ok);
      int n;
      n = 0;
      while ((busy || !tx_ready) && n < 3000) begin @(negedge clk); n++; end
      ok = (n < 3000);
   endtask

   // Keyboard model: waits for the request-to-send, then generates clock pulses
   // and samples the data line at the end of each high phase.
   task automatic dev_run(input bit ack, input int pulses, input bit glitch,
                          output logic [9:0] bits, output bit ok);
      int n;
      bits = '0;
      ok   = 1'b1;
      n = 0;
      while (!ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
      while (ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
      if (n >= 5000 || !ps2_data_oe) begin
         ok = 1'b0;
         return;
      end
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < pulses; i++) begin
         if (i == 10 && ack) begin
            dev_data_low = 1'b1;
            repeat (4) @(negedge clk);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         if (glitch && i == 3) begin
            repeat (10) @(negedge clk);
            dev_glitch = 1'b1;
            repeat (3) @(negedge clk);
            dev_glitch = 1'b0;
            repeat (HALF - 13) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
         if (i < 10) bits[i] = ps2_data_i;
         if (!busy) busy_gap++;
      end
      dev_data_low = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      compared++; if (tx_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", tx_ready); end
      compared++; if (tx_done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", tx_done); end
      compared++; if (tx_err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", tx_err); end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", busy); end
      compared++; if (ps2_clk_oe !== 1'b0) begin mismatched++; $display("FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
      compared++; if (ps2_data_oe !== 1'b0) begin mismatched++; $display("FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
   endtask

   task automatic test_set_led();
      logic [9:0] bits;
      logic [7:0] e;
      bit ok, idle_ok;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt; busy_gap = 0;
      fork
         send_byte(PS2_CMD_SET_LED);
         dev_run(1'b1, 11, 1'b0, bits, ok);
      join
      wait_idle(idle_ok);
      e = exp_q.pop_front();
      compared++; if (!(ok && idle_ok)) begin mismatched++; $display("FAIL setled_complete: request %b idle %b expected 1 1", ok, idle_ok); end
      compared++; if (bits !== model_frame(e)) begin mismatched++; $display("FAIL setled_frame: got %b expected %b", bits, model_frame(e)); end
      compared++; if (bits[8] !== 1'b1) begin mismatched++; $display("FAIL setled_parity: got %b expected 1", bits[8]); end
      compared++; if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL setled_done_pulses: got %0d expected 1", done_cnt - d0); end
      compared++; if (err_cnt != e0) begin mismatched++; $display("FAIL setled_err_pulses: got %0d expected 0", err_cnt - e0); end
      compared++; if (busy_gap != 0) begin mismatched++; $display("FAIL setled_busy: low samples %0d expected 0", busy_gap); end
   endtask

   task automatic test_enable();
      logic [9:0] bits;
      logic [7:0] e;
      bit ok, idle_ok;
      int d0;
      d0 = done_cnt;
      fork
         send_byte(PS2_CMD_ENABLE);
         dev_run(1'b1, 11, 1'b0, bits, ok);
      join
      wait_idle(idle_ok);
      e = exp_q.pop_front();
      compared++; if (bits !== model_frame(e)) begin mismatched++; $display("FAIL enable_frame: got %b expected %b", bits, model_frame(e)); end
      compared++; if (bits[8] !== 1'b0) begin mismatched++; $display("FAIL enable_parity: got %b expected 0", bits[8]); end
      compared++; if (last_inh_len != INHIBIT) begin mismatched++; $display("FAIL enable_inhibit_len: got %0d expected %0d", last_inh_len, INHIBIT); end
      compared++; if (!(ok && idle_ok) || done_cnt - d0 != 1) begin mismatched++; $display("FAIL enable_done: pulses %0d ok %b expected 1 1", done_cnt - d0, ok && idle_ok); end
   endtask

   task automatic test_random();
      logic [9:0] bits;
      logic [7:0] b, e;
      bit ok, idle_ok;
      int d0;
      for (int t = 0; t < 4; t++) begin
         b  = 8'($urandom_range(0, 255));
         d0 = done_cnt;
         fork
            send_byte(b);
            dev_run(1'b1, 11, 1'b0, bits, ok);
         join
         wait_idle(idle_ok);
         e = exp_q.pop_front();
         compared++; if (bits !== model_frame(e)) begin mismatched++; $display("FAIL random_frame[%0d]: got %b expected %b", t, bits, model_frame(e)); end
         compared++; if (!(ok && idle_ok) || done_cnt - d0 != 1) begin mismatched++; $display("FAIL random_done[%0d]: pulses %0d ok %b expected 1 1", t, done_cnt - d0, ok && idle_ok); end
      end
   endtask

   task automatic test_timeout();
      int n, d0, e0;
      logic oe_at_err;
      d0 = done_cnt; e0 = err_cnt;
      fork
         send_byte(PS2_CMD_RESET);
         begin
            n = 0;
            while (!ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
            while (ps2_clk_oe && n < 5000) begin @(negedge clk); n++; end
         end
      join
      void'(exp_q.pop_front());
      n = 0;
      while (!tx_err && n < 2 * TIMEOUT) begin @(negedge clk); n++; end
      oe_at_err = ps2_clk_oe | ps2_data_oe;
      compared++; if (n != TIMEOUT) begin mismatched++; $display("FAIL timeout_latency: got %0d expected %0d", n, TIMEOUT); end
      compared++; if (oe_at_err !== 1'b0) begin mismatched++; $display("FAIL timeout_release: got %b expected 0", oe_at_err); end
      repeat (2) @(negedge clk);
      compared++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL timeout_idle: ready %b busy %b expected 1 0", tx_ready, busy); end
      compared++; if (err_cnt - e0 != 1 || done_cnt != d0) begin mismatched++; $display("FAIL timeout_pulses: err %0d done %0d expected 1 0", err_cnt - e0, done_cnt - d0); end
   endtask

   task automatic test_no_ack();
      logic [9:0] bits;
      logic [7:0] b, e;
      bit ok, idle_ok;
      int d0, e0;
      b = 8'($urandom_range(0, 255));
      d0 = done_cnt; e0 = err_cnt;
      fork
         send_byte(b);
         dev_run(1'b0, 11, 1'b0, bits, ok);
      join
      wait_idle(idle_ok);
      e = exp_q.pop_front();
      compared++; if (bits !== model_frame(e)) begin mismatched++; $display("FAIL noack_frame: got %b expected %b", bits, model_frame(e)); end
      compared++; if (err_cnt - e0 != 1) begin mismatched++; $display("FAIL noack_err: got %0d expected 1", err_cnt - e0); end
      compared++; if (done_cnt != d0) begin mismatched++; $display("FAIL noack_done: got %0d expected 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid();
      logic [9:0] bits;
      logic [7:0] b, e;
      bit ok;
      int d0, e0;
      b = 8'($urandom_range(0, 255)) & 8'hEF;  // bit 4 = 0 so data is being driven low
      d0 = done_cnt; e0 = err_cnt;
      fork
         send_byte(b);
         dev_run(1'b1, 5, 1'b0, bits, ok);
      join
      e = exp_q.pop_front();
      repeat (5) @(negedge clk);
      compared++; if (bits[4:0] !== e[4:0]) begin mismatched++; $display("FAIL rstmid_bits: got %b expected %b", bits[4:0], e[4:0]); end
      compared++; if (dbg.state !== ST_BITS || ps2_data_oe !== 1'b1) begin mismatched++; $display("FAIL rstmid_pre: state %0d data_oe %b expected %0d 1", dbg.state, ps2_data_oe, ST_BITS); end
      rst = 1'b1;
      @(negedge clk);
      compared++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin mismatched++; $display("FAIL rstmid_release: clk_oe %b data_oe %b expected 0 0", ps2_clk_oe, ps2_data_oe); end
      compared++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_idle: ready %b busy %b expected 1 0", tx_ready, busy); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      compared++; if (done_cnt != d0 || err_cnt != e0) begin mismatched++; $display("FAIL rstmid_pulses: done %0d err %0d expected 0 0", done_cnt - d0, err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] bits1, bits2;
      logic [7:0] a, b, e;
      bit ok1, ok2, idle_ok;
      int n, d0, i0;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      d0 = done_cnt; i0 = inh_count;
      n = 0;
      while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
      tx_valid = 1'b1;
      tx_data  = a;
      exp_q.push_back(a);
      fork
         dev_run(1'b1, 11, 1'b1, bits1, ok1);
         begin
            n = 0;
            while (tx_ready && n < 100) begin @(negedge clk); n++; end
            tx_data = b;
         end
      join
      n = 0;
      while (!tx_done && n < 3000) begin @(negedge clk); n++; end
      compared++; if (!tx_done || ps2_clk_oe !== 1'b0 || inh_count - i0 != 1) begin mismatched++; $display("FAIL b2b_no_early_start: done %b clk_oe %b inhibits %0d expected 1 0 1", tx_done, ps2_clk_oe, inh_count - i0); end
      e = exp_q.pop_front();
      compared++; if (bits1 !== model_frame(e)) begin mismatched++; $display("FAIL b2b_first_frame: got %b expected %b", bits1, model_frame(e)); end
      exp_q.push_back(b);
      fork
         dev_run(1'b1, 11, 1'b0, bits2, ok2);
         begin
            n = 0;
            while (!tx_ready && n < 100) begin @(negedge clk); n++; end
            while (tx_ready && n < 200) begin @(negedge clk); n++; end
            tx_valid = 1'b0;
         end
      join
      wait_idle(idle_ok);
      e = exp_q.pop_front();
      compared++; if (bits2 !== model_frame(e)) begin mismatched++; $display("FAIL b2b_second_frame: got %b expected %b", bits2, model_frame(e)); end
      compared++; if (done_cnt - d0 != 2 || !(ok1 && ok2 && idle_ok)) begin mismatched++; $display("FAIL b2b_done: pulses %0d ok %b expected 2 1", done_cnt - d0, ok1 && ok2 && idle_ok); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_set_led();
      test_enable();
      test_random();
      test_timeout();
      test_no_ack();
      test_reset_mid();
      test_back_to_back();
      compared++; if (both_cnt != 0) begin mismatched++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
      compared++; if (ready_busy_cnt != 0) begin mismatched++; $display("FAIL ready_while_busy: got %0d expected 0", ready_busy_cnt); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
